// File: rtl/arbitro_param_if.sv
// Bundles the arbiter's FIFO-side signals. The arbiter uses the master modport;
// the FIFO environment (or a testbench) uses the slave modport.
interface arbitro_param_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 4,
    parameter int WIDTH = 12
);
    logic [N_IN-1:0]       empty;
    logic [N_IN*WIDTH-1:0] fifo_out;
    logic [N_OUT-1:0]      almost_full;
    logic [N_IN-1:0]       pop;
    logic [N_OUT-1:0]      push;
    logic [WIDTH-1:0]      data_out;
    logic                  dest_err;
    logic                  idle;

    modport master (
        input  empty, fifo_out, almost_full,
        output pop, push, data_out, dest_err, idle
    );

    modport slave (
        output empty, fifo_out, almost_full,
        input  pop, push, data_out, dest_err, idle
    );
endinterface

// File: rtl/arbitro_param.sv
// N_IN x N_OUT FIFO arbiter with fixed-priority or round-robin selection and
// out-of-range dest dropping. Define ARB_STATS_EN to add word_count/drop_count.
module arbitro_param #(
    parameter int N_IN     = 4,
    parameter int N_OUT    = 4,
    parameter int WIDTH    = 12,
    parameter int DEST_LSB = 8,
    parameter int DEST_W   = 2,
    parameter int MODE     = 1
) (
    input  logic            clk,
    input  logic            reset,
    arbitro_param_if.master bus
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]     word_count,
    output logic [7:0]      drop_count
`endif
);

    localparam int PTR_W = $clog2(N_IN);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [WIDTH-1:0]  headWord [N_IN];
    logic [DEST_W-1:0] headDest [N_IN];
    logic [N_IN-1:0]   eligible;

    logic              grantValid;
    logic [PTR_W-1:0]  grantIdx;
    logic [WIDTH-1:0]  gntWord;
    logic [DEST_W-1:0] gntDest;

    logic [N_OUT-1:0]  push_q, push_d;
    logic [WIDTH-1:0]  dataOut_q, dataOut_d;
    logic              destErr_q, destErr_d;
    logic [PTR_W-1:0]  rrPtr_q, rrPtr_d;
    state_t            state_q;
    logic              idle_q;

    // A head is blocked only by its own in-range destination being almost full;
    // out-of-range heads stay eligible so they can be drained and dropped.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            logic blocked;
            headWord[i] = bus.fifo_out[i*WIDTH +: WIDTH];
            headDest[i] = headWord[i][DEST_LSB +: DEST_W];
            blocked     = 1'b0;
            for (int o = 0; o < N_OUT; o++) begin
                if (int'(headDest[i]) == o) begin
                    blocked = bus.almost_full[o];
                end
            end
            eligible[i] = !bus.empty[i] && !blocked;
        end
    end

    // Scan in descending order so the lowest-ranked eligible candidate is kept.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
        if (MODE == 0) begin
            for (int i = N_IN - 1; i >= 0; i--) begin
                if (eligible[i]) begin
                    grantValid = 1'b1;
                    grantIdx   = PTR_W'(i);
                end
            end
        end else begin
            for (int k = N_IN - 1; k >= 0; k--) begin
                int idx;
                idx = (int'(rrPtr_q) + k) % N_IN;
                if (eligible[PTR_W'(idx)]) begin
                    grantValid = 1'b1;
                    grantIdx   = PTR_W'(idx);
                end
            end
        end
    end

    assign gntWord = headWord[grantIdx];
    assign gntDest = headDest[grantIdx];

    assign bus.pop = (grantValid && !reset) ? (N_IN'(1) << grantIdx) : '0;

    always_comb begin
        push_d    = '0;
        dataOut_d = dataOut_q;
        destErr_d = 1'b0;
        rrPtr_d   = rrPtr_q;
        if (grantValid) begin
            if (int'(gntDest) < N_OUT) begin
                push_d    = N_OUT'(1) << gntDest;
                dataOut_d = gntWord;
            end else begin
                destErr_d = 1'b1;
            end
            if (MODE != 0) begin
                rrPtr_d = (grantIdx == PTR_W'(N_IN - 1)) ? '0 : grantIdx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            push_q    <= '0;
            dataOut_q <= '0;
            destErr_q <= 1'b0;
            rrPtr_q   <= '0;
        end else begin
            push_q    <= push_d;
            dataOut_q <= dataOut_d;
            destErr_q <= destErr_d;
            rrPtr_q   <= rrPtr_d;
        end
    end

    // Masking with reset discards a push that is pending when reset arrives.
    assign bus.push     = reset ? '0 : push_q;
    assign bus.dest_err = destErr_q && !reset;
    assign bus.data_out = dataOut_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idle_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|eligible) begin
                        state_q <= ACTIVE;
                        idle_q  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (!grantValid && (push_q == '0) && !destErr_q) begin
                        state_q <= IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    idle_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.idle = idle_q;

`ifdef ARB_STATS_EN
    logic [15:0] wordCount_q;
    logic [7:0]  dropCount_q;

    // word_count wraps naturally; drop_count sticks at its maximum.
    always_ff @(posedge clk) begin
        if (reset) begin
            wordCount_q <= '0;
            dropCount_q <= '0;
        end else begin
            if (|push_q) begin
                wordCount_q <= wordCount_q + 16'd1;
            end
            if (destErr_q && (dropCount_q != 8'hFF)) begin
                dropCount_q <= dropCount_q + 8'd1;
            end
        end
    end

    assign word_count = wordCount_q;
    assign drop_count = dropCount_q;
`endif

endmodule
